// File: rtl/ysyx_23060332_seq.sv
// Multi-cycle instruction sequencer: owns the PC, runs the fetch/load-store handshakes, gates commit.
// Optional wait-state watchdog enabled by `YSYX_23060332_SEQ_TIMEOUT_EN.
module ysyx_23060332_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        ifu_rsp_ready,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        is_mem_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        halt_i,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    input  logic        reg_wen_i,
    output logic        reg_wen_o,
    output logic        busy,
    output logic        halted,
    output logic        timeout_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_WAIT,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        jump_q, jump_d;
    logic [31:1] jaddr_q, jaddr_d;
    logic        tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            jump_q  <= 1'b0;
            jaddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            jump_q  <= jump_d;
            jaddr_q <= jaddr_d;
        end
    end

`ifdef YSYX_23060332_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;
    logic       wait_st;
    logic       unused_timeout;

    assign wait_st = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                     (state_q == MEM_REQ)   || (state_q == MEM_WAIT);
    assign unused_timeout = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) cnt_q <= '0;
            else if (wait_st)       cnt_q <= cnt_q + 8'd1;
            err_q <= err_q | tmo_hit;
        end
    end
    assign timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        unique case (state_q)
            FETCH_REQ:  if (ifu_req_ready) state_d = FETCH_WAIT;
            FETCH_WAIT: if (ifu_rsp_valid) state_d = EXEC;
            EXEC: begin
                if (halt_i)        state_d = HALT;
                else if (is_mem_i) state_d = MEM_REQ;
                else               state_d = WB;
            end
            MEM_REQ:    if (lsu_req_ready) state_d = MEM_WAIT;
            MEM_WAIT:   if (lsu_rsp_valid) state_d = WB;
            WB:         state_d = FETCH_REQ;
            HALT:       state_d = HALT;
            default:    state_d = FETCH_REQ;
        endcase
`ifdef YSYX_23060332_SEQ_TIMEOUT_EN
        // Progress wins over the watchdog: only a stalled wait state can time out.
        tmo_hit = wait_st && (state_d == state_q) && ((cnt_q + 8'd1) == TIMEOUT);
        if (tmo_hit) state_d = HALT;
`endif
    end

    // Redirect is captured in EXEC so decode may move on before the WB commit.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        jump_d  = jump_q;
        jaddr_d = jaddr_q;
        if (state_q == FETCH_WAIT && ifu_rsp_valid) inst_d = ifu_rsp_inst;
        if (state_q == EXEC) begin
            jump_d  = jump_i;
            jaddr_d = jump_addr_i[31:1];
        end
        if (state_q == WB) pc_d = jump_q ? {jaddr_q, 1'b0} : pc_q + 32'd4;
    end

    always_comb begin
        ifu_req_valid = rst_n && (state_q == FETCH_REQ);
        ifu_rsp_ready = rst_n && (state_q == FETCH_WAIT);
        lsu_req_valid = rst_n && (state_q == MEM_REQ);
        reg_wen_o     = rst_n && (state_q == WB) && reg_wen_i;
        busy          = (state_q != HALT);
        halted        = (state_q == HALT);
        ifu_req_addr  = pc_q;
        pc_o          = pc_q;
        inst_o        = inst_q;
    end

endmodule

// File: tb/tb_ysyx_23060332_seq.sv
// Scoreboarded bench for ysyx_23060332_seq: fetch addresses checked by a monitor, timing by directed runs.
module tb_ysyx_23060332_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr, ifu_rsp_inst, inst_o, pc_o, jump_addr_i;
    logic        is_mem_i, jump_i, halt_i, lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        reg_wen_i, reg_wen_o, busy, halted, timeout_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef YSYX_23060332_SEQ_TIMEOUT_EN
    ysyx_23060332_seq #(.RESET_PC(32'h8000_0000), .TIMEOUT(8'd10)) dut (
`else
    ysyx_23060332_seq #(.RESET_PC(32'h8000_0000)) dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_ready(ifu_rsp_ready),
        .inst_o(inst_o), .pc_o(pc_o),
        .is_mem_i(is_mem_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i), .halt_i(halt_i),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .reg_wen_i(reg_wen_i), .reg_wen_o(reg_wen_o),
        .busy(busy), .halted(halted), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && ifu_req_valid && ifu_req_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: got addr %h expected no request", ifu_req_addr);
            end else begin
                check("fetch_addr", ifu_req_addr, exp_q.pop_front());
            end
        end
    end

    // Runs one instruction from FETCH_REQ; decode inputs are scrambled after EXEC.
    task automatic run_instr(input string name, input logic [31:0] inst, input logic mem,
                             input logic jmp, input logic [31:0] jaddr, input logic hlt,
                             input logic wen, input int lat, input int exp_cyc,
                             input int exp_wen, input int exp_lsuv);
        int cyc = 0, wens = 0, lsuv = 0;
        ifu_rsp_inst = inst; is_mem_i = mem; jump_i = jmp;
        jump_addr_i = jaddr; halt_i = hlt; reg_wen_i = wen;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (reg_wen_o) wens++;
            if (lsu_req_valid) begin
                lsuv++;
                lsu_req_ready = (lsuv > lat);
            end else begin
                lsu_req_ready = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc == 3) begin
                is_mem_i = ~mem; jump_i = ~jmp; jump_addr_i = ~jaddr; halt_i = ~hlt;
            end
            if (ifu_req_valid || halted || cyc >= 40) break;
        end
        lsu_req_ready = 1'b0;
        check({name, "_cycles"}, cyc, exp_cyc);
        check({name, "_wen_pulses"}, wens, exp_wen);
        check({name, "_lsu_valid_cycles"}, lsuv, exp_lsuv);
        check({name, "_inst"}, inst_o, inst);
    endtask

    task automatic step_pc(input string name, input logic [31:0] exp_pc);
        check({name, "_pc"}, pc_o, exp_pc);
        exp_q.push_back(exp_pc);
    endtask

    initial begin
        int n;
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0;
        is_mem_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0; halt_i = 1'b0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b1; reg_wen_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ifu_req_valid", ifu_req_valid, 0);
        check("rst_ifu_rsp_ready", ifu_rsp_ready, 0);
        check("rst_lsu_req_valid", lsu_req_valid, 0);
        check("rst_reg_wen_o", reg_wen_o, 0);
        check("rst_inst_o", inst_o, 32'h0000_0013);
        check("rst_pc_o", pc_o, 32'h8000_0000);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_halted", halted, 0);

        exp_q.push_back(32'h8000_0000);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        check("first_req_valid", ifu_req_valid, 1);
        check("first_req_addr", ifu_req_addr, 32'h8000_0000);

        run_instr("addi", 32'h0010_0093, 0, 0, 32'h0, 0, 1, 0, 4, 1, 0);
        step_pc("addi", 32'h8000_0004);
        run_instr("jal", 32'h0000_006f, 0, 1, 32'h8000_0101, 0, 1, 0, 4, 1, 0);
        step_pc("jal", 32'h8000_0100);
        run_instr("store", 32'h0010_2023, 1, 0, 32'h0, 0, 0, 3, 9, 0, 4);
        step_pc("store", 32'h8000_0104);
        run_instr("load", 32'h0000_2083, 1, 0, 32'h0, 0, 1, 0, 6, 1, 1);
        step_pc("load", 32'h8000_0108);
        run_instr("jalr_top", 32'h0000_8067, 0, 1, 32'hFFFF_FFFF, 0, 1, 0, 4, 1, 0);
        step_pc("jalr_top", 32'hFFFF_FFFE);
        run_instr("wrap", 32'h0000_0013, 0, 0, 32'h0, 0, 0, 0, 4, 0, 0);
        step_pc("wrap", 32'h0000_0002);

        // Reset while parked in MEM_WAIT.
        lsu_rsp_valid = 1'b0;
        ifu_rsp_inst = 32'h0010_2023; is_mem_i = 1'b1; jump_i = 1'b0; halt_i = 1'b0;
        n = 0;
        while (!lsu_req_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_reach_mem_req", lsu_req_valid, 1);
        lsu_req_ready = 1'b1;
        @(posedge clk); #1 lsu_req_ready = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_mem_wait", {lsu_req_valid, ifu_req_valid, busy}, 3'b001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ifu_req_valid", ifu_req_valid, 0);
        check("midrst_pc_o", pc_o, 32'h8000_0000);
        check("midrst_inst_o", inst_o, 32'h0000_0013);
        check("midrst_lsu_req_valid", lsu_req_valid, 0);
        lsu_rsp_valid = 1'b1;
        exp_q.push_back(32'h8000_0000);
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr("refetch", 32'h0010_0093, 0, 0, 32'h0, 0, 1, 0, 4, 1, 0);
        check("refetch_pc", pc_o, 32'h8000_0004);

        // Instruction memory never accepts.
        ifu_req_ready = 1'b0;
`ifdef YSYX_23060332_SEQ_TIMEOUT_EN
        n = 0;
        while (!halted && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles", n, 10);
        check("tmo_err", timeout_err, 1);
        check("tmo_busy", busy, 0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("stall_req_valid", ifu_req_valid, 1);
        check("stall_req_addr", ifu_req_addr, 32'h8000_0004);
        check("stall_timeout_err", timeout_err, 0);
        check("stall_busy", busy, 1);
`endif
        @(negedge clk) rst_n = 1'b0;
        ifu_req_ready = 1'b1;
        exp_q.push_back(32'h8000_0000);
        @(posedge clk); #1 rst_n = 1'b1;
        check("rerst_timeout_err", timeout_err, 0);

        run_instr("ebreak", 32'h0010_0073, 0, 0, 32'h0, 1, 1, 0, 3, 0, 0);
        check("ebreak_halted", halted, 1);
        check("ebreak_busy", busy, 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifu_req_valid || lsu_req_valid || reg_wen_o || ifu_rsp_ready) n++;
        end
        check("halt_quiet_cycles", n, 0);
        check("halt_pc_hold", pc_o, 32'h8000_0000);
        check("halt_inst_hold", inst_o, 32'h0010_0073);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
